// File: rtl/instr_cache_l1.sv
// Direct-mapped L1 instruction cache for the core fetch port.
// Lookups are combinational. A miss refills one whole line, one word at a
// time, over a req/ready interface to backing memory.
module instr_cache_l1 #(
  parameter int SETS        = 64,
  parameter int BLOCK_WORDS = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] pc_fi_i,
  input  logic [1:0]  pc_src_reg_i,
  input  logic        flush_i,
  output logic [31:0] instr_fi_o,
  output logic        instr_hit_fi_o,
  output logic        ic_repl_permit_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i
);

  localparam int CNT_W = $clog2(BLOCK_WORDS);
  localparam int OFF_W = CNT_W + 2;
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - OFF_W - IDX_W;

  localparam logic [31:0]      NOP_INSTR = 32'h0000_0013;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BLOCK_WORDS - 1);

  typedef enum logic {
    IDLE,
    REFILL
  } state_e;

  state_e state_q, state_d;

  // Fetch address split
  logic [CNT_W-1:0] pc_off;
  logic [IDX_W-1:0] pc_idx;
  logic [TAG_W-1:0] pc_tag;

  assign pc_off = pc_fi_i[OFF_W-1:2];
  assign pc_idx = pc_fi_i[OFF_W+IDX_W-1:OFF_W];
  assign pc_tag = pc_fi_i[31:OFF_W+IDX_W];

  // Line storage: valid bits are control state, tag and data are plain arrays
  logic [SETS-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS][BLOCK_WORDS];

  // Refill bookkeeping
  logic [TAG_W-1:0] miss_tag_q, miss_tag_d;
  logic [IDX_W-1:0] miss_idx_q, miss_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flush_pend_q, flush_pend_d;

  logic lookup_hit;
  logic accept_miss;
  logic beat;
  logic last_beat;

  assign lookup_hit  = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
  // The reset term keeps the permit low while the block is held in reset.
  assign accept_miss = (state_q == IDLE) && reset_i && !lookup_hit &&
                       (pc_src_reg_i == 2'b00) && !flush_i;
  assign beat        = (state_q == REFILL) && mem_ready_i;
  assign last_beat   = beat && (cnt_q == LAST_WORD);

  // State and control registers, cleared asynchronously
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      miss_tag_q   <= '0;
      miss_idx_q   <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      valid_q      <= valid_d;
      miss_tag_q   <= miss_tag_d;
      miss_idx_q   <= miss_idx_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Tag and data arrays: written by refill beats only
  // NOTE: no reset here; valid bits gate every read, so array contents never matter after reset.
  always_ff @(posedge clk_i) begin
    if (beat) begin
      data_q[miss_idx_q][cnt_q] <= mem_rdata_i;
    end
    if (last_beat) begin
      tag_q[miss_idx_q] <= miss_tag_q;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept_miss) state_d = REFILL;
      REFILL:  if (last_beat)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: miss capture, beat counter, valid bits, pending flush
  always_comb begin
    miss_tag_d   = miss_tag_q;
    miss_idx_d   = miss_idx_q;
    cnt_d        = cnt_q;
    valid_d      = valid_q;
    flush_pend_d = flush_pend_q;

    if (accept_miss) begin
      miss_tag_d = pc_tag;
      miss_idx_d = pc_idx;
      cnt_d      = '0;
    end

    if (state_q == IDLE && flush_i) begin
      valid_d = '0;
    end

    if (state_q == REFILL && flush_i) begin
      flush_pend_d = 1'b1;
    end

    if (beat) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // A flush seen at any point of the refill wipes the new line as well.
    if (last_beat) begin
      flush_pend_d = 1'b0;
      if (flush_pend_q || flush_i) begin
        valid_d = '0;
      end else begin
        valid_d[miss_idx_q] = 1'b1;
      end
    end
  end

  // Outputs: fetch response in IDLE, memory request in REFILL
  always_comb begin
    instr_fi_o       = NOP_INSTR;
    instr_hit_fi_o   = 1'b0;
    ic_repl_permit_o = 1'b0;
    mem_req_o        = 1'b0;
    mem_addr_o       = '0;
    unique case (state_q)
      IDLE: begin
        if (lookup_hit && !flush_i) begin
          instr_hit_fi_o = 1'b1;
          instr_fi_o     = data_q[pc_idx][pc_off];
        end
        ic_repl_permit_o = accept_miss;
      end
      REFILL: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {miss_tag_q, miss_idx_q, cnt_q, 2'b00};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_instr_cache_l1.sv
// Directed testbench for instr_cache_l1 (SETS=64, BLOCK_WORDS=4).
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_instr_cache_l1;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] pc_fi_i;
  logic [1:0]  pc_src_reg_i;
  logic        flush_i;
  logic [31:0] instr_fi_o;
  logic        instr_hit_fi_o;
  logic        ic_repl_permit_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ready_i;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  instr_cache_l1 #(.SETS(64), .BLOCK_WORDS(4)) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .pc_fi_i          (pc_fi_i),
    .pc_src_reg_i     (pc_src_reg_i),
    .flush_i          (flush_i),
    .instr_fi_o       (instr_fi_o),
    .instr_hit_fi_o   (instr_hit_fi_o),
    .ic_repl_permit_o (ic_repl_permit_o),
    .mem_req_o        (mem_req_o),
    .mem_addr_o       (mem_addr_o),
    .mem_rdata_i      (mem_rdata_i),
    .mem_ready_i      (mem_ready_i)
  );

  task automatic next_cycle;
    @(posedge clk_i);
    #1;
  endtask

  // One IDLE cycle that must miss and be granted a refill.
  task automatic miss_cycle(input string name, input logic [31:0] pc);
    pc_fi_i = pc;
    @(negedge clk_i);
    checks++;
    if ({instr_hit_fi_o, ic_repl_permit_o, mem_req_o} !== 3'b010) begin
      failures++;
      $display("FAIL %s miss@%h hit/permit/req=%b expected 010", name, pc,
               {instr_hit_fi_o, ic_repl_permit_o, mem_req_o});
    end
    checks++;
    if (instr_fi_o !== 32'h0000_0013) begin
      failures++;
      $display("FAIL %s miss_nop@%h instr=%h expected 00000013", name, pc, instr_fi_o);
    end
    next_cycle;
  endtask

  // One IDLE cycle that must hit with the given word.
  task automatic hit_cycle(input string name, input logic [31:0] pc, input logic [31:0] exp);
    pc_fi_i = pc;
    @(negedge clk_i);
    checks++;
    if ({instr_hit_fi_o, ic_repl_permit_o, mem_req_o} !== 3'b100) begin
      failures++;
      $display("FAIL %s hit@%h hit/permit/req=%b expected 100", name, pc,
               {instr_hit_fi_o, ic_repl_permit_o, mem_req_o});
    end
    checks++;
    if (instr_fi_o !== exp) begin
      failures++;
      $display("FAIL %s instr@%h got %h expected %h", name, pc, instr_fi_o, exp);
    end
    next_cycle;
  endtask

  // Serves a 4-word refill. stall[k] inserts one not-ready cycle before
  // beat k; flush_k pulses flush_i during that beat (-1 for none).
  task automatic refill_line(input string name, input logic [31:0] base,
                             input logic [31:0] dbase, input logic [3:0] stall,
                             input int flush_k);
    logic [31:0] exp_addr;
    for (int k = 0; k < 4; k++) begin
      exp_addr = base + 32'(4 * k);
      if (stall[k]) begin
        mem_ready_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== exp_addr) begin
          failures++;
          $display("FAIL %s stall%0d req=%b addr=%h expected req=1 addr=%h",
                   name, k, mem_req_o, mem_addr_o, exp_addr);
        end
        next_cycle;
      end
      mem_ready_i = 1'b1;
      mem_rdata_i = dbase + 32'(k);
      flush_i     = (k == flush_k);
      @(negedge clk_i);
      checks++;
      if (mem_req_o !== 1'b1 || mem_addr_o !== exp_addr) begin
        failures++;
        $display("FAIL %s beat%0d req=%b addr=%h expected req=1 addr=%h",
                 name, k, mem_req_o, mem_addr_o, exp_addr);
      end
      checks++;
      if ({instr_hit_fi_o, ic_repl_permit_o} !== 2'b00) begin
        failures++;
        $display("FAIL %s beat%0d_flags hit/permit=%b expected 00", name, k,
                 {instr_hit_fi_o, ic_repl_permit_o});
      end
      next_cycle;
    end
    mem_ready_i = 1'b0;
    flush_i     = 1'b0;
  endtask

  task automatic test_reset;
    reset_i      = 1'b0;
    pc_fi_i      = 32'h100;
    pc_src_reg_i = 2'b00;
    flush_i      = 1'b0;
    mem_rdata_i  = '0;
    mem_ready_i  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      checks++;
      if ({instr_hit_fi_o, ic_repl_permit_o, mem_req_o} !== 3'b000 ||
          mem_addr_o !== 32'h0 || instr_fi_o !== 32'h0000_0013) begin
        failures++;
        $display("FAIL reset_outputs cyc%0d hit/permit/req=%b addr=%h instr=%h expected 000/0/13",
                 c, {instr_hit_fi_o, ic_repl_permit_o, mem_req_o}, mem_addr_o, instr_fi_o);
      end
      @(posedge clk_i);
    end
    #1;
    reset_i = 1'b1;
  endtask

  task automatic test_basic_refill;
    miss_cycle("basic", 32'h100);
    refill_line("basic", 32'h100, 32'hA0, 4'b0000, -1);
    hit_cycle("basic", 32'h100, 32'hA0);
    hit_cycle("basic", 32'h10C, 32'hA3);
    hit_cycle("basic", 32'h104, 32'hA1);
  endtask

  task automatic test_evict;
    miss_cycle("evict", 32'h500);
    refill_line("evict", 32'h500, 32'hB0, 4'b0000, -1);
    hit_cycle("evict", 32'h508, 32'hB2);
    miss_cycle("evict_old", 32'h100);
    refill_line("evict_old", 32'h100, 32'hA0, 4'b0000, -1);
    hit_cycle("evict_old", 32'h104, 32'hA1);
  endtask

  task automatic test_stall;
    miss_cycle("stall", 32'h200);
    refill_line("stall", 32'h200, 32'hC0, 4'b1010, -1);
    hit_cycle("stall", 32'h200, 32'hC0);
    hit_cycle("stall", 32'h20C, 32'hC3);
  endtask

  task automatic test_redirect;
    pc_fi_i      = 32'h300;
    pc_src_reg_i = 2'b01;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      checks++;
      if ({instr_hit_fi_o, ic_repl_permit_o, mem_req_o} !== 3'b000) begin
        failures++;
        $display("FAIL redirect_hold cyc%0d hit/permit/req=%b expected 000", c,
                 {instr_hit_fi_o, ic_repl_permit_o, mem_req_o});
      end
      next_cycle;
    end
    pc_src_reg_i = 2'b00;
    miss_cycle("redirect", 32'h300);
    refill_line("redirect", 32'h300, 32'hD0, 4'b0000, -1);
    hit_cycle("redirect", 32'h304, 32'hD1);
  endtask

  task automatic test_flush_refill;
    miss_cycle("flush_refill", 32'h400);
    refill_line("flush_refill", 32'h400, 32'hE0, 4'b0000, 2);
    // Every line is gone, including 0x200: a held lookup shows no hit.
    pc_fi_i      = 32'h200;
    pc_src_reg_i = 2'b01;
    @(negedge clk_i);
    checks++;
    if ({instr_hit_fi_o, ic_repl_permit_o, mem_req_o} !== 3'b000) begin
      failures++;
      $display("FAIL flush_refill_0x200 hit/permit/req=%b expected 000",
               {instr_hit_fi_o, ic_repl_permit_o, mem_req_o});
    end
    next_cycle;
    pc_src_reg_i = 2'b00;
    miss_cycle("flush_refill_400", 32'h400);
    refill_line("flush_refill_400", 32'h400, 32'hE0, 4'b0000, -1);
    hit_cycle("flush_refill_400", 32'h400, 32'hE0);
    miss_cycle("flush_refill_100", 32'h100);
    refill_line("flush_refill_100", 32'h100, 32'hA0, 4'b0000, -1);
    hit_cycle("flush_refill_100", 32'h108, 32'hA2);
  endtask

  task automatic test_flush_idle;
    pc_fi_i = 32'h100;
    flush_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({instr_hit_fi_o, ic_repl_permit_o, mem_req_o} !== 3'b000 ||
        instr_fi_o !== 32'h0000_0013) begin
      failures++;
      $display("FAIL flush_idle hit/permit/req=%b instr=%h expected 000/00000013",
               {instr_hit_fi_o, ic_repl_permit_o, mem_req_o}, instr_fi_o);
    end
    next_cycle;
    flush_i      = 1'b0;
    pc_src_reg_i = 2'b10;
    @(negedge clk_i);
    checks++;
    if ({instr_hit_fi_o, ic_repl_permit_o, mem_req_o} !== 3'b000) begin
      failures++;
      $display("FAIL flush_idle_after hit/permit/req=%b expected 000",
               {instr_hit_fi_o, ic_repl_permit_o, mem_req_o});
    end
    next_cycle;
    pc_src_reg_i = 2'b00;
  endtask

  task automatic test_reset_mid_refill;
    miss_cycle("rst_mid", 32'h600);
    for (int k = 0; k < 3; k++) begin
      mem_ready_i = 1'b1;
      mem_rdata_i = 32'hF0 + 32'(k);
      next_cycle;
    end
    mem_ready_i = 1'b0;
    checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h60C) begin
      failures++;
      $display("FAIL rst_mid_pre req=%b addr=%h expected req=1 addr=0000060c",
               mem_req_o, mem_addr_o);
    end
    reset_i = 1'b0;
    #1;
    checks++;
    if (mem_req_o !== 1'b0 || mem_addr_o !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid_async req=%b addr=%h expected req=0 addr=0", mem_req_o, mem_addr_o);
    end
    next_cycle;
    next_cycle;
    reset_i = 1'b1;
    miss_cycle("rst_mid_after", 32'h600);
    refill_line("rst_mid_after", 32'h600, 32'h60, 4'b0000, -1);
    hit_cycle("rst_mid_after", 32'h608, 32'h62);
  endtask

  initial begin
    test_reset;
    test_basic_refill;
    test_evict;
    test_stall;
    test_redirect;
    test_flush_refill;
    test_flush_idle;
    test_reset_mid_refill;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
